// File: rtl/xpt_pkg.sv
// rtl/xpt_pkg.sv - shared XPT widths and execution-phase constants
package xpt_pkg;
   localparam int XPT_W = 5;

   typedef logic [XPT_W-1:0] xpt_t;

   localparam xpt_t XPT_MAX            = 5'd31;
   localparam xpt_t XPT_FETCH_RD_FIRST = 5'd1;
   localparam xpt_t XPT_FETCH_LATCH    = 5'd2;
   localparam xpt_t XPT_DECODE_FIRST   = 5'd3;

   localparam logic [7:0] OPC_NOP = 8'h00;
endpackage

// File: rtl/sequencer_xpt_source_if.sv
// rtl/sequencer_xpt_source_if.sv - bus between the sequencer, memory and the per-opcode decoders
interface sequencer_xpt_source_if;
   import xpt_pkg::*;

   logic       Wait;
   logic [7:0] DataIn;
   logic       PR_Reset_XPT;
   logic       P2_Set_CM1;
   logic       Pa_Ophd;
   xpt_t       XPT;
   xpt_t       notXPT;
   logic [7:0] Source;
   logic [7:0] notSource;
   logic       CM1;
   logic       Decode_Enable;
   logic       Fetch_Read;
   logic       Overrun;

   modport master (
      input  Wait, DataIn, PR_Reset_XPT, P2_Set_CM1, Pa_Ophd,
      output XPT, notXPT, Source, notSource, CM1, Decode_Enable, Fetch_Read, Overrun
   );

   modport slave (
      output Wait, DataIn, PR_Reset_XPT, P2_Set_CM1, Pa_Ophd,
      input  XPT, notXPT, Source, notSource, CM1, Decode_Enable, Fetch_Read, Overrun
   );
endinterface

// File: rtl/xpt_counter.sv
// rtl/xpt_counter.sv - XPT register with registered complement, restart priority and sticky overrun
module xpt_counter
   import xpt_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic hold,
   input  logic restart,
   output xpt_t xpt,
   output xpt_t not_xpt,
   output logic overrun
);

   xpt_t xpt_next;
   logic overrun_next;

   // Restart beats saturation, so a request at XPT_MAX never flags overrun.
   always_comb begin
      xpt_next     = xpt;
      overrun_next = overrun;
      if (restart) begin
         xpt_next = '0;
      end else if (xpt == XPT_MAX) begin
         overrun_next = 1'b1;
      end else begin
         xpt_next = xpt + XPT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xpt     <= '0;
         not_xpt <= '1;
         overrun <= 1'b0;
      end else if (!hold) begin
         xpt     <= xpt_next;
         not_xpt <= ~xpt_next;
         overrun <= overrun_next;
      end
   end

endmodule

// File: rtl/sequencer_xpt_source.sv
// rtl/sequencer_xpt_source.sv - execution-phase sequencer: opcode fetch, opcode latch and decode enable
module sequencer_xpt_source
   import xpt_pkg::*;
(
   input  logic                   Clock,
   input  logic                   notReset,
   sequencer_xpt_source_if.master bus
);

   logic       restart;
   logic       cm1_next;
   logic       de_next;
   logic       latch_opc;
   logic [7:0] source_q;
   logic [7:0] not_source_q;
   logic       cm1_q;
   logic       de_q;

   // End-of-instruction requests only count once the opcode is latched.
   assign restart   = bus.PR_Reset_XPT && de_q;
   assign latch_opc = !restart && cm1_q && (bus.XPT == XPT_FETCH_LATCH);

   xpt_counter u_xpt_counter (
      .clk     (Clock),
      .rst_n   (notReset),
      .hold    (bus.Wait),
      .restart (restart),
      .xpt     (bus.XPT),
      .not_xpt (bus.notXPT),
      .overrun (bus.Overrun)
   );

   always_comb begin
      cm1_next = cm1_q;
      de_next  = de_q;
      if (restart) begin
         cm1_next = bus.P2_Set_CM1;
         if (bus.Pa_Ophd) de_next = 1'b0;
      end else if (latch_opc) begin
         de_next = 1'b1;
      end else if (cm1_q && (bus.XPT == XPT_DECODE_FIRST)) begin
         cm1_next = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge notReset) begin
      if (!notReset) begin
         cm1_q        <= 1'b1;
         de_q         <= 1'b0;
         source_q     <= OPC_NOP;
         not_source_q <= ~OPC_NOP;
      end else if (!bus.Wait) begin
         cm1_q <= cm1_next;
         de_q  <= de_next;
         if (latch_opc) begin
            source_q     <= bus.DataIn;
            not_source_q <= ~bus.DataIn;
         end
      end
   end

   assign bus.CM1           = cm1_q;
   assign bus.Decode_Enable = de_q;
   assign bus.Source        = source_q;
   assign bus.notSource     = not_source_q;
   assign bus.Fetch_Read    = cm1_q && ((bus.XPT == XPT_FETCH_RD_FIRST) || (bus.XPT == XPT_FETCH_LATCH));

endmodule

// File: tb/tb_sequencer_xpt_source.sv
// tb/tb_sequencer_xpt_source.sv - scoreboard bench for sequencer_xpt_source
module tb_sequencer_xpt_source;

   logic Clock = 1'b0;
   logic notReset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   typedef struct {
      logic [4:0] x;
      logic       c;
      logic       d;
      logic [7:0] s;
      logic       o;
      int         id;
   } exp_t;

   exp_t q[$];
   event chk_ev;

   sequencer_xpt_source_if bus ();

   sequencer_xpt_source dut (
      .Clock    (Clock),
      .notReset (notReset),
      .bus      (bus)
   );

   always #5 Clock = ~Clock;

   task automatic compare(input exp_t e);
      logic fr;
      fr = e.c && (e.x == 5'd1 || e.x == 5'd2);
      checks++;
      if (bus.XPT !== e.x || bus.notXPT !== ~e.x || bus.Source !== e.s ||
          bus.notSource !== ~e.s || bus.CM1 !== e.c || bus.Decode_Enable !== e.d ||
          bus.Overrun !== e.o || bus.Fetch_Read !== fr) begin
         errors++;
         $display("FAIL step%0d: got xpt=%0d nxpt=%h src=%h nsrc=%h cm1=%b de=%b ovr=%b fr=%b, want xpt=%0d nxpt=%h src=%h nsrc=%h cm1=%b de=%b ovr=%b fr=%b",
                  e.id, bus.XPT, bus.notXPT, bus.Source, bus.notSource, bus.CM1,
                  bus.Decode_Enable, bus.Overrun, bus.Fetch_Read,
                  e.x, ~e.x, e.s, ~e.s, e.c, e.d, e.o, fr);
      end
   endtask

   initial begin
      forever begin
         @(negedge Clock or chk_ev);
         while (q.size() > 0) compare(q.pop_front());
      end
   end

   task automatic expect_now(input logic [4:0] ex, input logic ec, ed,
                             input logic [7:0] es, input logic eo);
      q.push_back('{ex, ec, ed, es, eo, step_no});
      step_no++;
      -> chk_ev;
   endtask

   // Drive inputs for one edge, then queue the state the DUT must show after that edge.
   task automatic step(input logic w, pr, p2, pa, input logic [7:0] din,
                       input logic [4:0] ex, input logic ec, ed,
                       input logic [7:0] es, input logic eo);
      bus.Wait         = w;
      bus.PR_Reset_XPT = pr;
      bus.P2_Set_CM1   = p2;
      bus.Pa_Ophd      = pa;
      bus.DataIn       = din;
      @(posedge Clock);
      q.push_back('{ex, ec, ed, es, eo, step_no});
      step_no++;
      @(negedge Clock);
   endtask

   task automatic idle(input logic [7:0] din, input logic [4:0] ex, input logic ec, ed,
                       input logic [7:0] es, input logic eo);
      step(1'b0, 1'b0, 1'b0, 1'b0, din, ex, ec, ed, es, eo);
   endtask

   task automatic fetch(input logic [7:0] op);
      idle(op, 5'd1, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(op, 5'd2, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(op, 5'd3, 1'b1, 1'b1, op, 1'b0);
   endtask

   task automatic async_reset();
      #2 notReset = 1'b0;
      #1 expect_now(5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge Clock);
      notReset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, want finish");
      $fatal(1);
   end

   initial begin
      bus.Wait = 1'b0; bus.PR_Reset_XPT = 1'b0; bus.P2_Set_CM1 = 1'b0;
      bus.Pa_Ophd = 1'b0; bus.DataIn = 8'hC8;
      @(negedge Clock);
      #1 expect_now(5'd0, 1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge Clock);
      notReset = 1'b1;

      // Free run with no requests: saturate at 31 and flag overrun.
      fetch(8'hC8);
      for (int k = 4; k <= 31; k++) idle(8'hC8, 5'(k), 1'b0, 1'b1, 8'hC8, 1'b0);
      idle(8'hC8, 5'd31, 1'b0, 1'b1, 8'hC8, 1'b1);
      idle(8'hC8, 5'd31, 1'b0, 1'b1, 8'hC8, 1'b1);

      async_reset();

      // RET Z not taken at XPT 4, then wait-stretched fetch.
      fetch(8'hC9);
      idle(8'hC9, 5'd4, 1'b0, 1'b1, 8'hC9, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'hC9, 5'd0, 1'b1, 1'b0, 8'hC9, 1'b0);
      idle(8'h10, 5'd1, 1'b1, 1'b0, 8'hC9, 1'b0);
      idle(8'h10, 5'd2, 1'b1, 1'b0, 8'hC9, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 5'd2, 1'b1, 1'b0, 8'hC9, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 5'd2, 1'b1, 1'b0, 8'hC9, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 5'd2, 1'b1, 1'b0, 8'hC9, 1'b0);
      idle(8'h44, 5'd3, 1'b1, 1'b1, 8'h44, 1'b0);
      idle(8'h44, 5'd4, 1'b0, 1'b1, 8'h44, 1'b0);
      // Request during wait is held off until the first non-wait edge.
      step(1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 5'd4, 1'b0, 1'b1, 8'h44, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 5'd0, 1'b1, 1'b0, 8'h44, 1'b0);
      idle(8'h44, 5'd1, 1'b1, 1'b0, 8'h44, 1'b0);
      // Request at XPT 1 of a fetch is ignored.
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC9, 5'd2, 1'b1, 1'b0, 8'h44, 1'b0);
      idle(8'hC9, 5'd3, 1'b1, 1'b1, 8'hC9, 1'b0);
      idle(8'hC9, 5'd4, 1'b0, 1'b1, 8'hC9, 1'b0);
      // Non-fetch restart keeps Source and CM1 low.
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC9, 5'd0, 1'b0, 1'b1, 8'hC9, 1'b0);
      idle(8'h66, 5'd1, 1'b0, 1'b1, 8'hC9, 1'b0);
      idle(8'h66, 5'd2, 1'b0, 1'b1, 8'hC9, 1'b0);
      idle(8'h66, 5'd3, 1'b0, 1'b1, 8'hC9, 1'b0);
      for (int k = 4; k <= 7; k++) idle(8'h66, 5'(k), 1'b0, 1'b1, 8'hC9, 1'b0);

      async_reset();

      // Request at XPT 31 wins over saturation.
      fetch(8'hA5);
      for (int k = 4; k <= 31; k++) idle(8'hA5, 5'(k), 1'b0, 1'b1, 8'hA5, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0);
      idle(8'hA5, 5'd1, 1'b1, 1'b0, 8'hA5, 1'b0);

      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequencer_xpt_source.md
# sequencer_xpt_source

Execution-phase sequencer feeding every per-opcode decoder. It owns the 5-bit execution-phase timer (XPT) and the latched opcode register (Source), and drives both in true and complement form. It runs the fixed opcode-fetch phases and enables decoding once the opcode is latched. It consumes the decoders' end-of-instruction strobes (`PR_Reset_XPT`, `P2_Set_CM1`, `Pa_Ophd`) to restart the timer for the next fetch.

## Interface
Parameters: none; widths and phase constants come from the shared package.

Ports:
- `Clock`  in  1  single system clock; all state updates on rising edge
- `notReset`  in  1  reset, asynchronous assert, active-low
- `Wait`  in  1  bus wait; freezes all sequencer state while high
- `DataIn`  in  8  memory data bus; opcode byte during fetch
- `PR_Reset_XPT`  in  1  OR of all decoders' end-of-instruction request
- `P2_Set_CM1`  in  1  next cycle is an opcode fetch (M1)
- `Pa_Ophd`  in  1  opcode-handled acknowledge; clears `Decode_Enable`
- `XPT`  out  5  execution-phase timer
- `notXPT`  out  5  bitwise complement of `XPT`
- `Source`  out  8  latched opcode
- `notSource`  out  8  bitwise complement of `Source`
- `CM1`  out  1  current machine cycle is an opcode fetch
- `Decode_Enable`  out  1  `enable` for the per-opcode decoders
- `Fetch_Read`  out  1  memory read strobe for the opcode fetch
- `Overrun`  out  1  sticky; XPT reached its maximum without a reset request

## Operation
- Reset (`notReset`=0, asynchronous): `XPT`=0, `notXPT`=5'h1F, `CM1`=1, `Source`=8'h00 (NOP), `notSource`=8'hFF, `Decode_Enable`=0, `Overrun`=0. The first fetch starts at the first edge after release.
- Phases with `CM1`=1:
  - XPT 0: address phase.
  - XPT 1–2: `Fetch_Read`=1.
  - End of XPT 2 (rising edge with `Wait`=0): `Source`<=`DataIn`, `notSource`<=~`DataIn`, `Decode_Enable`<=1. From that edge the decoders see the new opcode at XPT 3.
  - Rising edge leaving XPT 3: `CM1`<=0.
- `Fetch_Read` is combinational: `CM1` & (XPT==1 | XPT==2).
- XPT rule, evaluated at each rising edge with `Wait`=0, in priority order:
  1. `PR_Reset_XPT`=1 and `Decode_Enable`=1: XPT<=0. `CM1`<=`P2_Set_CM1`. If `Pa_Ophd`=1, `Decode_Enable`<=0.
  2. XPT==31: hold at 31 and set `Overrun`.
  3. Otherwise XPT<=XPT+1.
- `PR_Reset_XPT` while `Decode_Enable`=0 (XPT 0–2 of a fetch) is ignored.
- `PR_Reset_XPT` without `P2_Set_CM1` restarts XPT at 0 with `CM1`=0. This is a non-fetch machine-cycle restart and `Source` is kept.
- `Wait`=1: XPT, `Source`, `CM1`, `Decode_Enable` and `Overrun` all hold. All strobes are ignored for that edge. The decoders keep presenting their requests because XPT is unchanged.
- `Overrun` clears only on reset.
- `notXPT` and `notSource` are registered alongside their true forms. They must never be formed by an output inverter, so both polarities change on the same edge.

## Timing
- Minimum instruction: fetch XPT 0–3, then the decoder's reset request at XPT 3 or later. Next fetch XPT 0 follows one cycle after the request edge.
- Opcode visible to decoders 1 cycle after the XPT 2 edge; no combinational path from `DataIn` to `Source`.
- Reset-request-to-XPT=0 latency: 1 cycle (registered).
- Reset request at XPT 31: the reset wins, XPT<=0, and `Overrun` does not set.
- Reset request and `Wait` on the same edge: `Wait` wins; the request is honoured on the first non-wait edge.
- `notReset` asserted mid-instruction forces the reset values immediately, regardless of `Clock`.

## Structure
- Shared package `xpt_pkg`, used by every decoder that compares XPT:
  - `XPT_W`=5, `XPT_MAX`=31
  - `XPT_FETCH_RD_FIRST`=1, `XPT_FETCH_LATCH`=2, `XPT_DECODE_FIRST`=3
  - `OPC_NOP`=8'h00
- One natural sub-module, `xpt_counter`: the XPT register with its complement, the priority next-state logic and the saturation/`Overrun` logic.
- The opcode latch and the `CM1`/`Decode_Enable` flags stay in the top module.

## Test plan
- Reset then idle with `DataIn`=8'hC8 and no requests: XPT runs 0,1,2,3,…,31 and holds. `Source`=8'hC8 from XPT 3; `notSource`=8'h37. `CM1` drops after XPT 3. `Overrun` rises on the edge that would pass 31.
- RET Z with Z=0 (decoder requests `PR_Reset_XPT`+`P2_Set_CM1`+`Pa_Ophd` at XPT 4): next cycle XPT=0, `CM1`=1, `Decode_Enable`=0. `Fetch_Read` is high at XPT 1–2 of the next fetch.
- `Wait`=1 for 3 cycles at XPT 2 with `DataIn` changing: XPT stays 2 and `Source` is unchanged. `Source` latches the value present at the first non-wait edge.
- `PR_Reset_XPT` pulsed at XPT 1 of a fetch: ignored, XPT goes to 2.
- `PR_Reset_XPT` at XPT 31 with `Overrun`=0: XPT=0 and `Overrun` stays 0.
- `notReset` pulsed low at XPT 7 with `Source`=8'hC9: XPT=0 and `Source`=8'h00 immediately, `CM1`=1, `notXPT`=5'h1F.
